// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: execute-to-memory pipeline stage with a 2-entry skid buffer.
// The output register O drives out_*; the skid register S catches one op
// when the memory stage stalls. in_ready depends only on registered state.
// Optional feature macro: EX_MEM_FWD_EN adds the fwd_valid/fwd_dest/fwd_data
// bypass outputs, taken combinationally from O.
module ex_mem_pipe #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic          in_msb,
  input  logic          in_zero,
  input  logic [DW-1:0] in_st_data,
  input  logic [RW-1:0] in_dest,
  input  logic          in_regwrite,
  input  logic          in_memread,
  input  logic          in_memwrite,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_msb,
  output logic          out_zero,
  output logic [DW-1:0] out_st_data,
  output logic [RW-1:0] out_dest,
  output logic          out_regwrite,
  output logic          out_memread,
  output logic          out_memwrite
`ifdef EX_MEM_FWD_EN
  ,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_dest,
  output logic [DW-1:0] fwd_data
`endif
);

  // One op travels as a single packed word so O and S stay in lockstep.
  localparam int PW = 2*DW + RW + 5;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] o_q, o_d;
  logic [PW-1:0] s_q, s_d;
  logic          o_v_q, o_v_d;
  logic          s_v_q, s_v_d;
  logic          push, pop;

  assign in_pl = {in_result, in_msb, in_zero, in_st_data, in_dest,
                  in_regwrite, in_memread, in_memwrite};

  assign in_ready = ~s_v_q;
  assign push     = in_valid & in_ready;
  assign pop      = o_v_q & out_ready;

  // Next-state routing between input, skid and output registers.
  always_comb begin
    o_d   = o_q;
    s_d   = s_q;
    o_v_d = o_v_q;
    s_v_d = s_v_q;
    if (flush) begin
      // Squash everything; data regs keep their stale contents.
      o_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (pop && s_v_q) begin
      // Skid refills output; no push possible since in_ready was low.
      o_d   = s_q;
      o_v_d = 1'b1;
      s_v_d = 1'b0;
    end else if (push && (!o_v_q || pop)) begin
      o_d   = in_pl;
      o_v_d = 1'b1;
    end else if (push) begin
      // Output is held by a stall: park the op in the skid register.
      s_d   = in_pl;
      s_v_d = 1'b1;
    end else if (pop) begin
      o_v_d = 1'b0;
    end
  end

  // State registers; reset clears valids and all payload bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q   <= '0;
      s_q   <= '0;
      o_v_q <= 1'b0;
      s_v_q <= 1'b0;
    end else begin
      o_q   <= o_d;
      s_q   <= s_d;
      o_v_q <= o_v_d;
      s_v_q <= s_v_d;
    end
  end

  assign out_valid = o_v_q;
  assign {out_result, out_msb, out_zero, out_st_data, out_dest,
          out_regwrite, out_memread, out_memwrite} = o_q;

`ifdef EX_MEM_FWD_EN
  // Bypass only register-writing non-loads: load data is not ready yet.
  assign fwd_valid = o_v_q & out_regwrite & ~out_memread;
  assign fwd_dest  = out_dest;
  assign fwd_data  = out_result;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe using a scoreboard queue of expected ops.
// Define EX_MEM_FWD_EN to also exercise the forwarding outputs.
module tb_ex_mem_pipe;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int PW = 2*DW + RW + 5;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [DW-1:0] in_result, in_st_data;
  logic          in_msb, in_zero;
  logic [RW-1:0] in_dest;
  logic          in_regwrite, in_memread, in_memwrite;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result, out_st_data;
  logic          out_msb, out_zero;
  logic [RW-1:0] out_dest;
  logic          out_regwrite, out_memread, out_memwrite;
`ifdef EX_MEM_FWD_EN
  logic          fwd_valid;
  logic [RW-1:0] fwd_dest;
  logic [DW-1:0] fwd_data;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] sb_q[$];

  ex_mem_pipe #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_msb(in_msb), .in_zero(in_zero),
    .in_st_data(in_st_data), .in_dest(in_dest),
    .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_msb(out_msb), .out_zero(out_zero),
    .out_st_data(out_st_data), .out_dest(out_dest),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite)
`ifdef EX_MEM_FWD_EN
    ,
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  wire [PW-1:0] in_pl  = {in_result, in_msb, in_zero, in_st_data, in_dest,
                          in_regwrite, in_memread, in_memwrite};
  wire [PW-1:0] out_pl = {out_result, out_msb, out_zero, out_st_data, out_dest,
                          out_regwrite, out_memread, out_memwrite};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: check occupancy-derived handshakes and the head op each cycle,
  // then retire pops and record accepted pushes (model decides acceptance).
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      logic exp_valid, exp_ready;
      exp_valid = (sb_q.size() > 0);
      exp_ready = (sb_q.size() < 2);
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
      chk("in_ready",  {63'd0, in_ready},  {63'd0, exp_ready});
      if (exp_valid) begin
        chk("head_op", {24'd0, out_pl}, {24'd0, sb_q[0]});
`ifdef EX_MEM_FWD_EN
        chk("fwd_valid", {63'd0, fwd_valid},
            {63'd0, sb_q[0][2] & ~sb_q[0][1]});
        chk("fwd_data", {48'd0, fwd_data}, {48'd0, sb_q[0][PW-1 -: DW]});
`endif
        if (out_ready) begin
          $display("pop  result=%04h dest=%0d rw=%b mr=%b mw=%b",
                   out_result, out_dest, out_regwrite, out_memread, out_memwrite);
          void'(sb_q.pop_front());
        end
      end
      if (flush) begin
        $display("flush squashes %0d op(s)", sb_q.size());
        sb_q.delete();
      end else if (in_valid && exp_ready) begin
        $display("push result=%04h dest=%0d", in_result, in_dest);
        sb_q.push_back(in_pl);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [DW-1:0] r, input logic [RW-1:0] d,
                     input logic rw, input logic mr, input logic mw);
    in_valid    = v;
    in_result   = r;
    in_msb      = r[DW-1];
    in_zero     = (r == '0);
    in_st_data  = ~r;
    in_dest     = d;
    in_regwrite = rw;
    in_memread  = mr;
    in_memwrite = mw;
  endtask

  task automatic push1(input logic [DW-1:0] r);
    drv(1'b1, r, r[RW-1:0], 1'b1, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (sb_q.size() > 0 && k < 20) begin
      step();
      k++;
    end
    if (sb_q.size() > 0) chk("drain_timeout", 64'd1, 64'd0);
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_result",    {48'd0, out_result}, 64'd0);

    // Back-to-back stream at full throughput.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 16'(i), 3'(i), 1'b1, 1'b0, 1'b0);
      step();
      chk("stream_result", {48'd0, out_result}, 64'(i));
    end
    drain();

    // Stall: two fill O and S, third is held off.
    out_ready = 1'b0;
    push1(16'hAAAA);
    push1(16'h5555);
    drv(1'b1, 16'h1111, 3'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall_hold",     {48'd0, out_result}, 64'hAAAA);
    out_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (!(sb_q.size() < 2) && k < 20) begin step(); k++; end
      step();
      in_valid = 1'b0;
    end
    drain();

    // Flush with O and S full and an op offered in the same cycle.
    out_ready = 1'b0;
    push1(16'h0101);
    push1(16'h0202);
    flush = 1'b1;
    drv(1'b1, 16'h7777, 3'd7, 1'b1, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
    push1(16'h0303);
    drain();

    // Single pop with both full: skid moves to output, fields intact.
    out_ready = 1'b0;
    push1(16'h0A0A);
    drv(1'b1, 16'h0B0B, 3'd5, 1'b0, 1'b0, 1'b1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("skid_in_ready", {63'd0, in_ready},     64'd1);
    chk("skid_result",   {48'd0, out_result},   64'h0B0B);
    chk("skid_dest",     {61'd0, out_dest},     64'd5);
    chk("skid_memwrite", {63'd0, out_memwrite}, 64'd1);
    chk("skid_st_data",  {48'd0, out_st_data},  64'hF4F4);
    drain();

`ifdef EX_MEM_FWD_EN
    out_ready = 1'b0;
    drv(1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    chk("fwd_on_valid", {63'd0, fwd_valid}, 64'd1);
    chk("fwd_on_dest",  {61'd0, fwd_dest},  64'd3);
    chk("fwd_on_data",  {48'd0, fwd_data},  64'h1234);
    drain();
    out_ready = 1'b0;
    drv(1'b1, 16'h1234, 3'd3, 1'b1, 1'b1, 1'b0);
    step(); in_valid = 1'b0;
    chk("fwd_load", {63'd0, fwd_valid}, 64'd0);
    drain();
    out_ready = 1'b0;
    drv(1'b1, 16'h1234, 3'd3, 1'b0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    chk("fwd_norw", {63'd0, fwd_valid}, 64'd0);
    drain();
`endif

    // Mid-stream reset, asserted together with flush.
    out_ready = 1'b0;
    push1(16'h0C0C);
    push1(16'h0D0D);
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("midrst_result",    {48'd0, out_result}, 64'd0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      drv(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
